// File: rtl/lc3_alu_exec.sv
// LC-3 operate-instruction execute/writeback stage (ADD/AND/NOT).
// Drives the register file read ports, waits out its read latency, then writes back and updates NZP.
`timescale 1ns/1ps
module lc3_alu_exec #(
  parameter int READ_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        IR_valid,
  input  logic [15:0] IR,
  output logic        IR_ready,
  output logic [2:0]  SR1_addr,
  output logic [2:0]  SR2_addr,
  input  logic [15:0] SR1_data,
  input  logic [15:0] SR2_data,
  output logic        LD_REG,
  output logic [2:0]  DR_addr,
  output logic [15:0] WB_data,
  output logic        N,
  output logic        Z,
  output logic        P,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB, S_FAULT} state_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [1:0] LAT    = 2'(READ_LAT);

  state_t      state, state_next;
  logic [1:0]  wait_cnt;
  logic [3:0]  op_q;
  logic        imm_sel_q;
  logic [4:0]  imm5_q;
  logic        op_legal;
  logic [15:0] operand_b;
  logic [15:0] alu_result;

  assign op_legal = (IR[15:12] == OP_ADD) || (IR[15:12] == OP_AND) ||
                    (IR[15:12] == OP_NOT);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (IR_valid) state_next = op_legal ? S_READ : S_FAULT;
      S_READ:  if (wait_cnt == 2'd1) state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      S_WB:    state_next = S_IDLE;
      S_FAULT: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    operand_b = imm_sel_q ? {{11{imm5_q[4]}}, imm5_q} : SR2_data;
    case (op_q)
      OP_ADD:  alu_result = SR1_data + operand_b;
      OP_AND:  alu_result = SR1_data & operand_b;
      default: alu_result = ~SR1_data;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      IR_ready  <= 1'b1;
      LD_REG    <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      SR1_addr  <= '0;
      SR2_addr  <= '0;
      DR_addr   <= '0;
      WB_data   <= '0;
      N         <= 1'b0;
      Z         <= 1'b1;
      P         <= 1'b0;
      wait_cnt  <= '0;
      op_q      <= '0;
      imm_sel_q <= 1'b0;
      imm5_q    <= '0;
    end else begin
      // Status outputs are registered copies of the state being entered.
      IR_ready <= (state_next == S_IDLE);
      LD_REG   <= (state_next == S_WB);
      done     <= (state_next == S_WB);
      illegal  <= (state_next == S_FAULT);
      case (state)
        S_IDLE: if (IR_valid) begin
          op_q      <= IR[15:12];
          imm_sel_q <= IR[5];
          imm5_q    <= IR[4:0];
          DR_addr   <= IR[11:9];
          SR1_addr  <= IR[8:6];
          SR2_addr  <= IR[2:0];
          wait_cnt  <= LAT;
        end
        S_READ: wait_cnt <= wait_cnt - 2'd1;
        S_EXEC: WB_data  <= alu_result;
        S_WB: begin
          N <= WB_data[15];
          Z <= (WB_data == 16'h0000);
          P <= !WB_data[15] && (WB_data != 16'h0000);
        end
        default: ;
      endcase
    end
  end

endmodule
